// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks the EX/MEM/WB occupants and derives operand selects and a stall.
module fwd_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        freeze,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_read;
  } entry_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  entry_t ex_q, mem_q, wb_q;
  entry_t id_entry;
  logic   bubble_in;

  // MEM is the most recent producer, so it is checked before WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input entry_t    mem_e,
                                         input entry_t    wb_e);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_e.valid && mem_e.reg_write && (mem_e.dst != 5'd0) && (mem_e.dst == src))
      sel = FWD_MEM;
    else if (wb_e.valid && wb_e.reg_write && (wb_e.dst != 5'd0) && (wb_e.dst == src))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = 1'b1;
    id_entry.rs        = id_rs;
    id_entry.rt        = id_rt;
    id_entry.uses_rt   = id_uses_rt;
    id_entry.dst       = id_dst;
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
  end

  always_comb begin
    stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dst != 5'd0) &&
            ((ex_q.dst == id_rs) || (id_uses_rt && (ex_q.dst == id_rt))) &&
            !flush && !freeze;
  end

  assign bubble_in = flush || stall || !id_valid;

  // Selects are purely a function of registered entries.
  always_comb begin
    forward_a = fwd_sel(ex_q.rs, mem_q, wb_q);
    forward_b = ex_q.uses_rt ? fwd_sel(ex_q.rt, mem_q, wb_q) : FWD_RF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= 16'd0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble_in ? entry_t'('0) : id_entry;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: per-cycle expectations are queued by
// the driver and compared by an independent negedge monitor.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  id_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        freeze;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic [15:0] stall_cnt;

  // {forward_a, forward_b, stall, stall_cnt}
  logic [20:0] exp_q[$];
  int          n_checks;
  int          n_errors;
  int          step_no;

  fwd_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .freeze       (freeze),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .stall_cnt    (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [1:0] fa, input logic [1:0] fb,
                          input logic st, input logic [15:0] cnt);
    exp_q.push_back({fa, fb, st, cnt});
  endtask

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [4:0] dst, input logic rw,
                      input logic mr, input logic fl, input logic fz,
                      input logic [1:0] efa, input logic [1:0] efb,
                      input logic est, input logic [15:0] ecnt);
    @(posedge clk);
    #1;
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = ut;
    id_dst       = dst;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    freeze       = fz;
    step_no      = step_no + 1;
    push_exp(efa, efb, est, ecnt);
  endtask

  task automatic nop(input logic [1:0] efa, input logic [1:0] efb,
                     input logic est, input logic [15:0] ecnt);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, efa, efb, est, ecnt);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [20:0] e;
      e = exp_q.pop_front();
      n_checks = n_checks + 1;
      if ({forward_a, forward_b, stall, stall_cnt} !== e) begin
        n_errors = n_errors + 1;
        $display("FAIL step%0d: got fa=%b fb=%b stall=%b cnt=%0d, want fa=%b fb=%b stall=%b cnt=%0d",
                 step_no, forward_a, forward_b, stall, stall_cnt,
                 e[20:19], e[18:17], e[16], e[15:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_errors     = 0;
    step_no      = 0;
    rst_n        = 1'b0;
    id_valid     = 1'b0;
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    id_dst       = 5'd0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    flush        = 1'b0;
    freeze       = 1'b0;

    // reset state
    @(posedge clk); #1; push_exp(2'b00, 2'b00, 1'b0, 16'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // add $3, then consumer with rs=$3: MEM forward, then back to 00
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    step(1, 5'd3, 5'd4, 1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    nop(2'b10, 2'b00, 0, 16'd0);
    nop(2'b00, 2'b00, 0, 16'd0);
    nop(2'b00, 2'b00, 0, 16'd0);

    // add $3; nop; sub rs=$3 -> WB forward
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    nop(2'b00, 2'b00, 0, 16'd0);
    step(1, 5'd3, 5'd0, 0, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    nop(2'b01, 2'b00, 0, 16'd0);

    // add $3; add $3; sub rs=$3 -> MEM wins
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    step(1, 5'd3, 5'd0, 0, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    nop(2'b10, 2'b00, 0, 16'd0);
    nop(2'b00, 2'b00, 0, 16'd0);
    nop(2'b00, 2'b00, 0, 16'd0);
    nop(2'b00, 2'b00, 0, 16'd0);

    // lw $5; add rt=$5 -> one stall cycle, then WB forward on b
    step(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 16'd0);
    step(1, 5'd2, 5'd5, 1, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00, 1, 16'd0);
    step(1, 5'd2, 5'd5, 1, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd1);
    nop(2'b00, 2'b01, 0, 16'd1);
    nop(2'b00, 2'b00, 0, 16'd1);
    nop(2'b00, 2'b00, 0, 16'd1);
    nop(2'b00, 2'b00, 0, 16'd1);

    // lw $5; add rt=$5 with flush -> no stall, count unchanged
    step(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 16'd1);
    step(1, 5'd2, 5'd5, 1, 5'd8, 1, 0, 1, 0, 2'b00, 2'b00, 0, 16'd1);
    nop(2'b00, 2'b00, 0, 16'd1);
    nop(2'b00, 2'b00, 0, 16'd1);
    nop(2'b00, 2'b00, 0, 16'd1);

    // lw $5; add rs=$5 under freeze for 3 cycles, then one stall
    step(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 16'd1);
    step(1, 5'd5, 5'd0, 0, 5'd9, 1, 0, 0, 1, 2'b00, 2'b00, 0, 16'd1);
    step(1, 5'd5, 5'd0, 0, 5'd9, 1, 0, 0, 1, 2'b00, 2'b00, 0, 16'd1);
    step(1, 5'd5, 5'd0, 0, 5'd9, 1, 0, 0, 1, 2'b00, 2'b00, 0, 16'd1);
    step(1, 5'd5, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 1, 16'd1);
    step(1, 5'd5, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd2);
    nop(2'b01, 2'b00, 0, 16'd2);
    nop(2'b00, 2'b00, 0, 16'd2);
    nop(2'b00, 2'b00, 0, 16'd2);
    nop(2'b00, 2'b00, 0, 16'd2);

    // write to $0 then consumer of $0 -> no forwarding
    step(1, 5'd1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd2);
    step(1, 5'd0, 5'd0, 1, 5'd10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd2);
    nop(2'b00, 2'b00, 0, 16'd2);
    nop(2'b00, 2'b00, 0, 16'd2);

    // load into $0 then consumer of $0 -> no stall
    step(1, 5'd1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 16'd2);
    step(1, 5'd0, 5'd0, 1, 5'd11, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'd2);
    nop(2'b00, 2'b00, 0, 16'd2);
    nop(2'b00, 2'b00, 0, 16'd2);

    // reset pulse in the middle of a stall
    step(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 16'd2);
    step(1, 5'd5, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 1, 16'd2);
    @(posedge clk); #1; rst_n = 1'b0; step_no = step_no + 1;
    push_exp(2'b00, 2'b00, 1'b0, 16'd0);
    @(posedge clk); #1; rst_n = 1'b1; step_no = step_no + 1;
    push_exp(2'b00, 2'b00, 1'b0, 16'd0);
    nop(2'b00, 2'b00, 0, 16'd0);
    // first edge after release advances: add rs=$5 now in EX, lw gone
    nop(2'b00, 2'b00, 0, 16'd0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors = n_errors + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
